// File: rtl/feed_scheduler.sv
// Feed scheduler: matches three schedule slots against live time, runs a timed dispense and drives a 50 Hz servo PWM.
// Optional completed-dispense counter is built only when FEED_COUNT_EN is defined; otherwise feed_count is tied to zero.
//
// state | meaning
// IDLE  | servo closed (unless manual open), waiting for a slot trigger
// OPEN  | dispensing; prescaler/sec_left time the open period
module feed_scheduler #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PWM_PERIOD    = 1000000,
    parameter int PULSE_CLOSED  = 50000,
    parameter int PULSE_OPEN    = 100000,
    parameter int MAX_DURATION  = 60
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic [31:0] currHour,
    input  logic [31:0] currMin,
    input  logic [31:0] currAmpm,
    input  logic [31:0] hour1,
    input  logic [31:0] min1,
    input  logic [31:0] ampm1,
    input  logic [31:0] hour2,
    input  logic [31:0] min2,
    input  logic [31:0] ampm2,
    input  logic [31:0] hour3,
    input  logic [31:0] min3,
    input  logic [31:0] ampm3,
    input  logic [31:0] duration,
    input  logic [31:0] pwmControl,
    output logic        servo_pwm,
    output logic        dispensing,
    output logic [2:0]  feed_event,
    output logic [15:0] feed_count
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int WW = PW + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
    localparam logic [WW-1:0] W_CLOSED  = WW'(PULSE_CLOSED);
    localparam logic [WW-1:0] W_OPEN    = WW'(PULSE_OPEN);
    localparam logic [7:0]    MAX_DUR   = 8'(MAX_DURATION);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    state_t        state;
    logic [7:0]    sec_left;
    logic [TW-1:0] prescaler;
    logic [7:0]    last_min;
    logic [2:0]    fired;
    logic [PW-1:0] pwm_cnt;
    logic [WW-1:0] width;

    logic [7:0] slot_hour [3];
    logic [7:0] slot_min  [3];
    logic       slot_ampm [3];
    logic [2:0] match;
    logic [2:0] fired_eff;
    logic [2:0] trigger;
    logic       min_changed;
    logic [7:0] dur_clamped;
    logic       open_req;
    logic [WW-1:0] width_next;
    logic       unused_bits;

    function automatic logic slot_valid(input logic [7:0] h, input logic [7:0] m);
        return (h >= 8'd1) && (h <= 8'd12) && (m <= 8'd59);
    endfunction

    always_comb begin
        slot_hour[0] = hour1[7:0];
        slot_hour[1] = hour2[7:0];
        slot_hour[2] = hour3[7:0];
        slot_min[0]  = min1[7:0];
        slot_min[1]  = min2[7:0];
        slot_min[2]  = min3[7:0];
        slot_ampm[0] = ampm1[0];
        slot_ampm[1] = ampm2[0];
        slot_ampm[2] = ampm3[0];
    end

    always_comb begin
        match = '0;
        for (int k = 0; k < 3; k++) begin
            match[k] = pwmControl[1]
                     && slot_valid(slot_hour[k], slot_min[k])
                     && (slot_hour[k] == currHour[7:0])
                     && (slot_min[k] == currMin[7:0])
                     && (slot_ampm[k] == currAmpm[0]);
        end
    end

    // A new minute re-arms every slot in the same cycle it is observed.
    assign min_changed = (currMin[7:0] != last_min);
    assign fired_eff   = min_changed ? 3'b000 : fired;
    assign trigger     = match & ~fired_eff;
    assign dur_clamped = (duration[7:0] > MAX_DUR) ? MAX_DUR : duration[7:0];

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            last_min <= 8'hFF;
            fired    <= 3'b000;
        end else begin
            last_min <= currMin[7:0];
            fired    <= fired_eff | match;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state      <= IDLE;
            sec_left   <= 8'd0;
            prescaler  <= '0;
            feed_event <= 3'b000;
            dispensing <= 1'b0;
        end else begin
            feed_event <= 3'b000;
            case (state)
                IDLE: begin
                    if ((|trigger) && (dur_clamped != 8'd0)) begin
                        state      <= OPEN;
                        dispensing <= 1'b1;
                        feed_event <= trigger;
                        sec_left   <= dur_clamped;
                        prescaler  <= '0;
                    end
                end
                OPEN: begin
                    if (prescaler == TICK_LAST) begin
                        prescaler <= '0;
                        sec_left  <= sec_left - 8'd1;
                        if (sec_left == 8'd1) begin
                            state      <= IDLE;
                            dispensing <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + TW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    dispensing <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEED_COUNT_EN
    logic dispense_done;

    assign dispense_done = (state == OPEN) && (prescaler == TICK_LAST) && (sec_left == 8'd1);

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            feed_count <= 16'h0000;
        end else if (dispense_done && (feed_count != 16'hFFFF)) begin
            feed_count <= feed_count + 16'd1;
        end
    end
`else
    assign feed_count = 16'h0000;
`endif

    // Width is only re-sampled at the frame start so a frame never carries a runt pulse.
    assign open_req   = (state == OPEN) || pwmControl[0];
    assign width_next = (pwm_cnt == '0) ? (open_req ? W_OPEN : W_CLOSED) : width;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            pwm_cnt   <= '0;
            width     <= W_CLOSED;
            servo_pwm <= 1'b0;
        end else begin
            pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PW'(1);
            width     <= width_next;
            servo_pwm <= ({1'b0, pwm_cnt} < width_next);
        end
    end

    assign unused_bits = ^{currHour[31:8], currMin[31:8], currAmpm[31:1],
                           hour1[31:8], min1[31:8], ampm1[31:1],
                           hour2[31:8], min2[31:8], ampm2[31:1],
                           hour3[31:8], min3[31:8], ampm3[31:1],
                           duration[31:8], pwmControl[31:2]};

endmodule

// File: tb/tb_feed_scheduler.sv
// Directed bench for feed_scheduler with a feed_event scoreboard queue.
// Expected feed_count follows FEED_COUNT_EN; undefined means it must stay zero.
module tb_feed_scheduler;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic [31:0] currHour, currMin, currAmpm;
    logic [31:0] hour1, min1, ampm1, hour2, min2, ampm2, hour3, min3, ampm3;
    logic [31:0] duration, pwmControl;
    logic        servo_pwm, dispensing;
    logic [2:0]  feed_event;
    logic [15:0] feed_count;

    int n_assert = 0;
    int n_fail   = 0;
    int ev_total = 0;
    int disp_total = 0;
    int exp_count = 0;
    logic [2:0] exp_q [$];

    feed_scheduler #(
        .TICKS_PER_SEC(100),
        .PWM_PERIOD   (20),
        .PULSE_CLOSED (2),
        .PULSE_OPEN   (4),
        .MAX_DURATION (60)
    ) dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .currHour    (currHour),
        .currMin     (currMin),
        .currAmpm    (currAmpm),
        .hour1       (hour1),
        .min1        (min1),
        .ampm1       (ampm1),
        .hour2       (hour2),
        .min2        (min2),
        .ampm2       (ampm2),
        .hour3       (hour3),
        .min3        (min3),
        .ampm3       (ampm3),
        .duration    (duration),
        .pwmControl  (pwmControl),
        .servo_pwm   (servo_pwm),
        .dispensing  (dispensing),
        .feed_event  (feed_event),
        .feed_count  (feed_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (feed_event != 3'b000) ev_total++;
        if (dispensing === 1'b1) disp_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_fc();
`ifdef FEED_COUNT_EN
        return 32'(exp_count);
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_time(input int h, input int m, input int a);
        currHour = 32'(h);
        currMin  = 32'(m);
        currAmpm = 32'(a);
    endtask

    task automatic wait_feed(input string tag);
        logic [2:0] exp;
        int n;
        exp = exp_q.pop_front();
        n = 0;
        while (feed_event == 3'b000 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_event"}, 32'(feed_event), 32'(exp));
        chk({tag, "_disp_on"}, 32'(dispensing), 32'd1);
        @(negedge clock);
        chk({tag, "_event_1cyc"}, 32'(feed_event), 32'd0);
    endtask

    task automatic measure_open(input string tag, input int exp_len);
        int n;
        int hi;
        n = 1;
        hi = 0;
        while (dispensing === 1'b1 && n < 7000) begin
            if (n >= 40 && n < 80) hi += int'(servo_pwm);
            n++;
            @(negedge clock);
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
        if (exp_len >= 80) chk({tag, "_servo_open"}, 32'(hi), 32'd8);
        exp_count++;
        chk({tag, "_count"}, 32'(feed_count), exp_fc());
    endtask

    task automatic pwm_high(input int cycles, output int hi);
        hi = 0;
        repeat (cycles) begin
            @(negedge clock);
            hi += int'(servo_pwm);
        end
    endtask

    task automatic wait_servo(input logic val);
        int n;
        n = 0;
        while (servo_pwm !== val && n < 60) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_len(output int len);
        len = 0;
        while (servo_pwm === 1'b1 && len < 30) begin
            len++;
            @(negedge clock);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int e0;
        int d0;
        e0 = ev_total;
        d0 = disp_total;
        repeat (cycles) @(negedge clock);
        chk({tag, "_no_event"}, 32'(ev_total - e0), 32'd0);
        chk({tag, "_no_open"}, 32'(disp_total - d0), 32'd0);
    endtask

    initial begin
        int hi;
        int len;

        ctrl_reset_n = 1'b0;
        set_time(0, 0, 0);
        hour1 = 0; min1 = 0; ampm1 = 0;
        hour2 = 0; min2 = 0; ampm2 = 0;
        hour3 = 0; min3 = 0; ampm3 = 0;
        duration = 0;
        pwmControl = 0;
        repeat (3) @(negedge clock);
        chk("rst_disp", 32'(dispensing), 32'd0);
        chk("rst_event", 32'(feed_event), 32'd0);
        chk("rst_count", 32'(feed_count), 32'd0);
        chk("rst_servo", 32'(servo_pwm), 32'd0);
        ctrl_reset_n = 1'b1;

        // Idle: closed pulses only; hour1=0 with currHour=0 must not match.
        pwm_high(40, hi);
        chk("idle_servo", 32'(hi), 32'd4);
        expect_quiet("idle", 20);

        // Basic dispense.
        hour1 = 8; min1 = 30; ampm1 = 0;
        duration = 3;
        pwmControl = 2;
        set_time(8, 30, 0);
        exp_q.push_back(3'b001);
        wait_feed("basic");
        measure_open("basic", 300);
        expect_quiet("basic_no_retrig", 60);

        // Two slots at 7:00 PM produce a single dispense.
        hour1 = 7; min1 = 0; ampm1 = 1;
        hour3 = 7; min3 = 0; ampm3 = 1;
        duration = 1;
        set_time(6, 59, 1);
        expect_quiet("pre_7pm", 10);
        set_time(7, 0, 1);
        exp_q.push_back(3'b101);
        wait_feed("two_slot");
        measure_open("two_slot", 100);

        // Gating: zero duration, then a nonzero duration in the same minute stays fired.
        hour3 = 0;
        hour1 = 9; min1 = 15; ampm1 = 0;
        duration = 0;
        set_time(9, 15, 0);
        expect_quiet("dur_zero", 30);
        duration = 2;
        expect_quiet("dur_zero_fired", 30);

        pwmControl = 0;
        hour1 = 9; min1 = 16;
        set_time(9, 16, 0);
        expect_quiet("sched_off", 30);

        pwmControl = 2;
        hour1 = 0; min1 = 0; ampm1 = 0;
        set_time(0, 0, 0);
        expect_quiet("hour_zero", 30);

        hour1 = 5; min1 = 60;
        set_time(5, 60, 0);
        expect_quiet("min_range", 30);

        // Manual open widens only from the next frame boundary.
        pwmControl = 0;
        wait_servo(1'b1);
        wait_servo(1'b0);
        pwmControl = 1;
        wait_servo(1'b1);
        run_len(len);
        chk("manual_open_width", 32'(len), 32'd4);
        pwmControl = 0;
        wait_servo(1'b1);
        run_len(len);
        chk("manual_close_width", 32'(len), 32'd2);
        chk("manual_disp", 32'(dispensing), 32'd0);
        chk("manual_count", 32'(feed_count), exp_fc());

        // Duration clamps to MAX_DURATION seconds.
        hour1 = 11; min1 = 11; ampm1 = 0;
        duration = 200;
        pwmControl = 2;
        set_time(11, 11, 0);
        exp_q.push_back(3'b001);
        wait_feed("clamp");
        measure_open("clamp", 6000);

        // Reset mid-dispense.
        hour1 = 10; min1 = 45; ampm1 = 0;
        duration = 3;
        set_time(10, 45, 0);
        exp_q.push_back(3'b001);
        wait_feed("rst_mid");
        repeat (50) @(negedge clock);
        #3;
        ctrl_reset_n = 1'b0;
        #1;
        chk("rst_mid_disp", 32'(dispensing), 32'd0);
        chk("rst_mid_servo", 32'(servo_pwm), 32'd0);
        chk("rst_mid_count", 32'(feed_count), 32'd0);
        exp_count = 0;
        pwmControl = 0;
        repeat (3) @(negedge clock);
        ctrl_reset_n = 1'b1;
        pwm_high(40, hi);
        chk("rst_after_servo", 32'(hi), 32'd4);
        expect_quiet("rst_no_resume", 10);
        pwmControl = 2;
        exp_q.push_back(3'b001);
        wait_feed("rst_retrig");
        measure_open("rst_retrig", 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
